// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs fields into a word and queues {instr, err} in a small FIFO.
// Optional round-trip self-check through a decoder is enabled by defining ENCODER_ROUNDTRIP_CHECK_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef OPCODE_ALU
`define OPCODE_ALU    7'b0110011
`define OPCODE_LOAD   7'b0000011
`define OPCODE_STORE  7'b0100011
`define OPCODE_BRANCH 7'b1100011
`define OPCODE_JUMP   7'b1101111
`endif

`ifdef ENCODER_ROUNDTRIP_CHECK_EN
module instr_roundtrip_dec (
  input  logic [`WORD_SIZE-1:0]          instr,
  input  logic [2:0]                     fmt,
  output logic [`ARCH_REG_INDEX_SIZE-1:0] rs1,
  output logic [`ARCH_REG_INDEX_SIZE-1:0] rs2,
  output logic [`ARCH_REG_INDEX_SIZE-1:0] rd,
  output logic [`WORD_SIZE-1:0]          imm
);
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  // Rebuild the sign-extended immediate from the format's scattered bit layout
  always_comb begin
    imm = 32'h0000_0000;
    case (fmt)
      3'd1:    imm = {{20{instr[31]}}, instr[31:20]};
      3'd2:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd3:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd4:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'd5:    imm = {instr[31:12], 12'h000};
      default: imm = 32'h0000_0000;
    endcase
  end
endmodule
`endif

module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     fmt,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic [6:0]                     funct7,
  input  logic [`ARCH_REG_INDEX_SIZE-1:0] rs1,
  input  logic [`ARCH_REG_INDEX_SIZE-1:0] rs2,
  input  logic [`ARCH_REG_INDEX_SIZE-1:0] rd,
  input  logic [`WORD_SIZE-1:0]          imm,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [`WORD_SIZE-1:0]          out_instr,
  output logic                           out_err,
  output logic [CNT_W-1:0]               count,
  output logic                           chk_mismatch
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [`WORD_SIZE-1:0] NOP = 32'h0000_0013;

  logic [`WORD_SIZE-1:0] enc_instr;
  logic                  enc_err;
  logic                  i_bad, b_bad, j_bad, u_bad;
  logic [`WORD_SIZE-1:0] instr_mem [DEPTH];
  logic                  err_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push, pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != {CNT_W{1'b0}});
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = instr_mem[rd_ptr];
  assign out_err   = err_mem[rd_ptr];

  assign i_bad = (imm != {{20{imm[11]}}, imm[11:0]});
  assign b_bad = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
  assign j_bad = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
  assign u_bad = (imm[11:0] != 12'h000);

  // Field packing per format; out-of-range immediates still encode their truncated bits
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (fmt)
      3'd0: begin
        enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err   = 1'b0;
      end
      3'd1: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = i_bad;
      end
      3'd2: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err   = i_bad;
      end
      3'd3: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err   = b_bad;
      end
      3'd4: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err   = j_bad;
      end
      3'd5: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_err   = u_bad;
      end
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy; reset clears contents so the head reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= 32'h0000_0000;
        err_mem[i]   <= 1'b0;
      end
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= enc_instr;
        err_mem[wr_ptr]   <= enc_err;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef ENCODER_ROUNDTRIP_CHECK_EN
  logic [2:0]                     fmt_mem [DEPTH];
  logic [`ARCH_REG_INDEX_SIZE-1:0] rs1_mem [DEPTH];
  logic [`ARCH_REG_INDEX_SIZE-1:0] rs2_mem [DEPTH];
  logic [`ARCH_REG_INDEX_SIZE-1:0] rd_mem  [DEPTH];
  logic [`WORD_SIZE-1:0]          imm_mem [DEPTH];
  logic [`WORD_SIZE-1:0]          trunc_imm;
  logic [`ARCH_REG_INDEX_SIZE-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [`WORD_SIZE-1:0]          dec_imm;
  logic                           mismatch;
  logic [2:0]                     head_fmt;

  // Reference immediate reduced to what the format can actually carry
  always_comb begin
    trunc_imm = 32'h0000_0000;
    case (fmt)
      3'd1, 3'd2: trunc_imm = {{20{imm[11]}}, imm[11:0]};
      3'd3:       trunc_imm = {{19{imm[12]}}, imm[12:1], 1'b0};
      3'd4:       trunc_imm = {{11{imm[20]}}, imm[20:1], 1'b0};
      3'd5:       trunc_imm = {imm[31:12], 12'h000};
      default:    trunc_imm = 32'h0000_0000;
    endcase
  end

  // Side storage of the source fields, written in lockstep with the word FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fmt_mem[i] <= 3'd0;
        rs1_mem[i] <= '0;
        rs2_mem[i] <= '0;
        rd_mem[i]  <= '0;
        imm_mem[i] <= 32'h0000_0000;
      end
    end else if (push) begin
      fmt_mem[wr_ptr] <= fmt;
      rs1_mem[wr_ptr] <= rs1;
      rs2_mem[wr_ptr] <= rs2;
      rd_mem[wr_ptr]  <= rd;
      imm_mem[wr_ptr] <= trunc_imm;
    end
  end

  assign head_fmt = fmt_mem[rd_ptr];

  instr_roundtrip_dec u_dec (
    .instr (out_instr),
    .fmt   (head_fmt),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd),
    .imm   (dec_imm)
  );

  // Compare only the fields each format actually carries
  always_comb begin
    mismatch = 1'b0;
    case (head_fmt)
      3'd0:       mismatch = (dec_rs1 != rs1_mem[rd_ptr]) || (dec_rs2 != rs2_mem[rd_ptr]) ||
                             (dec_rd != rd_mem[rd_ptr]);
      3'd1:       mismatch = (dec_rs1 != rs1_mem[rd_ptr]) || (dec_rd != rd_mem[rd_ptr]) ||
                             (dec_imm != imm_mem[rd_ptr]);
      3'd2, 3'd3: mismatch = (dec_rs1 != rs1_mem[rd_ptr]) || (dec_rs2 != rs2_mem[rd_ptr]) ||
                             (dec_imm != imm_mem[rd_ptr]);
      3'd4, 3'd5: mismatch = (dec_rd != rd_mem[rd_ptr]) || (dec_imm != imm_mem[rd_ptr]);
      default:    mismatch = 1'b0;
    endcase
  end

  // Sticky flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_mismatch <= 1'b0;
    end else if (pop && !out_err && mismatch) begin
      chk_mismatch <= 1'b1;
    end else begin
      chk_mismatch <= chk_mismatch;
    end
  end
`else
  // Round-trip checking is compiled out; flag stays low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_mismatch <= 1'b0;
    end else begin
      chk_mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic against a queue model.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef OPCODE_ALU
`define OPCODE_ALU    7'b0110011
`define OPCODE_LOAD   7'b0000011
`define OPCODE_STORE  7'b0100011
`define OPCODE_BRANCH 7'b1100011
`define OPCODE_JUMP   7'b1101111
`endif

module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [2:0] fmt = 3'd0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [31:0] imm = 32'd0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic out_err;
  logic [CNT_W-1:0] count;
  logic chk_mismatch;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .count(count), .chk_mismatch(chk_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {err, word} from the ISA field rules using plain integer arithmetic
  function automatic logic [32:0] ref_encode(input int f, input int opc, input int f3, input int f7,
                                             input int s1, input int s2, input int d, input int im);
    logic [31:0] u = im;
    logic [31:0] w;
    bit e;
    case (f)
      0: begin w = f7 * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15) + f3 * (1 << 12) + d * (1 << 7) + opc; e = 0; end
      1: begin
        e = !(im >= -2048 && im <= 2047);
        w = ((u & 32'hfff) << 20) | s1 << 15 | f3 << 12 | d << 7 | opc;
      end
      2: begin
        e = !(im >= -2048 && im <= 2047);
        w = (((u >> 5) & 32'h7f) << 25) | s2 << 20 | s1 << 15 | f3 << 12 | ((u & 32'h1f) << 7) | opc;
      end
      3: begin
        e = !(im >= -4096 && im <= 4095 && (im % 2 == 0));
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) | s2 << 20 | s1 << 15 |
            f3 << 12 | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7) | opc;
      end
      4: begin
        e = !(im >= -(1 << 20) && im < (1 << 20) && (im % 2 == 0));
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 32'h1) << 20) |
            (((u >> 12) & 32'hff) << 12) | d << 7 | opc;
      end
      5: begin e = (u % 4096) != 0; w = (u & 32'hfffff000) | d << 7 | opc; end
      default: begin w = 32'h0000_0013; e = 1; end
    endcase
    return {e, w};
  endfunction

  // Scoreboard: observe handshakes mid-cycle, model the queue in order
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("count", 32'(count), 32'(exp_q.size()));
      check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check_eq("head_instr", out_instr, exp_q[0][31:0]);
          check_eq("head_err", 32'(out_err), 32'(exp_q[0][32]));
          void'(exp_q.pop_front());
        end else begin
          check_eq("pop_nonempty", 32'd1, 32'(exp_q.size()));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_encode(int'(fmt), int'(opcode), int'(funct3), int'(funct7),
                                   int'(rs1), int'(rs2), int'(rd), int'($signed(imm))));
    end
  end

  task automatic set_fields(input int f, input logic [6:0] opc, input int f3, input int f7,
                            input int s1, input int s2, input int d, input int im);
    fmt = 3'(f); opcode = opc; funct3 = 3'(f3); funct7 = 7'(f7);
    rs1 = 5'(s1); rs2 = 5'(s2); rd = 5'(d); imm = 32'(im);
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic send(input int f, input logic [6:0] opc, input int f3, input int f7,
                      input int s1, input int s2, input int d, input int im);
    int n = 0;
    set_fields(f, opc, f3, f7, s1, s2, d, im);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Push into an empty FIFO, check the head against a fixed expectation, then pop it
  task automatic directed(input string tag, input int f, input logic [6:0] opc, input int f3, input int f7,
                          input int s1, input int s2, input int d, input int im,
                          input logic [31:0] exp_w, input logic exp_e);
    send(f, opc, f3, f7, s1, s2, d, im);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_instr"}, out_instr, exp_w);
    check_eq({tag, "_err"}, 32'(out_err), 32'(exp_e));
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    check_eq("rst_chk", 32'(chk_mismatch), 32'd0);
    #11 reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    directed("r_add",  0, `OPCODE_ALU,    0, 0, 2, 3, 1, 0,     32'h003100b3, 1'b0);
    directed("i_load", 1, `OPCODE_LOAD,   2, 0, 3, 0, 1, 1,     32'h0011a083, 1'b0);
    directed("s_st",   2, `OPCODE_STORE,  2, 0, 3, 1, 0, 1,     32'h0011a0a3, 1'b0);
    directed("b_beq",  3, `OPCODE_BRANCH, 0, 0, 1, 1, 0, -24,   32'hfe1084e3, 1'b0);
    directed("j_jal1", 4, `OPCODE_JUMP,   0, 0, 0, 0, 1, -16,   32'hff1ff0ef, 1'b0);
    directed("j_jal0", 4, `OPCODE_JUMP,   0, 0, 0, 0, 0, -20,   32'hfedff06f, 1'b0);
    directed("i_oor",  1, `OPCODE_LOAD,   2, 0, 3, 0, 1, 2048,  32'h8001a083, 1'b1);
    directed("b_odd",  3, `OPCODE_BRANCH, 0, 0, 1, 1, 0, 3,     32'h00108163, 1'b1);
    directed("bad_fmt",7, `OPCODE_ALU,    5, 9, 4, 6, 7, 123,   32'h00000013, 1'b1);

    // Backpressure: fill, hold off a fifth request, then drain in order
    for (int i = 0; i < DEPTH; i++) send(1, `OPCODE_ALU, i, 0, i + 1, 0, i + 2, i * 8);
    set_fields(5, `OPCODE_ALU, 0, 0, 0, 0, 9, 32'h12345000);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("full_count", 32'(count), 32'(DEPTH));
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH) @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("drain_count", 32'(count), 32'd0);
    check_eq("drain_valid", 32'(out_valid), 32'd0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) send(0, `OPCODE_ALU, i, 32, i, i + 1, i + 2, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    exp_q.delete();
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    #4 reset = 1'b0;
    @(posedge clk);
    #1;
    directed("post_rst", 0, `OPCODE_ALU, 0, 0, 2, 3, 1, 0, 32'h003100b3, 1'b0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      int im;
      case ($urandom_range(0, 3))
        0: im = int'($urandom);
        1: im = int'($urandom_range(0, 8191)) - 4096;
        2: im = int'($urandom_range(0, 32'h3fffff)) - 32'h200000;
        default: im = int'($urandom & 32'hfffff000);
      endcase
      set_fields(int'($urandom_range(0, 7)), 7'($urandom), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), im);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    check_eq("final_count", 32'(count), 32'd0);
    check_eq("final_chk", 32'(chk_mismatch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
RV32 instruction encoder: the inverse of the decoder. It takes opcode, funct3, funct7, register indices, a format select and a full-width immediate, packs them into a `WORD_SIZE instruction word, and queues the result in a small FIFO behind a valid/ready handshake. It feeds the test program loader and instruction-memory preload path. It also serves as a round-trip stimulus generator for the decoder.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >= 2)
CNT_W, $clog2(DEPTH+1), width of occupancy counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  request carries fields to encode
in_ready  output  1  encoder can accept (FIFO not full)
fmt  input  3  0=R 1=I 2=S 3=B 4=J 5=U, 6-7 illegal
opcode  input  7  opcode field (`OPCODE_ALU, `OPCODE_LOAD, `OPCODE_STORE, `OPCODE_BRANCH, `OPCODE_JUMP, ...)
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R only)
rs1  input  `ARCH_REG_INDEX_SIZE  source 1
rs2  input  `ARCH_REG_INDEX_SIZE  source 2
rd  input  `ARCH_REG_INDEX_SIZE  destination
imm  input  `WORD_SIZE  signed immediate / PC-relative byte offset
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head
out_instr  output  `WORD_SIZE  encoded word at head
out_err  output  1  head entry had illegal fmt or out-of-range imm
count  output  CNT_W  FIFO occupancy
chk_mismatch  output  1  sticky round-trip check failure (see Optional Feature)

Behaviour:
- Reset (async, active-high): FIFO emptied, count=0, out_valid=0, out_instr=0, out_err=0, chk_mismatch=0, in_ready=1 after reset deasserts.
- Accept when in_valid && in_ready at rising edge; encode is combinational on inputs, and the {instr, err} pair is written to the tail.
- Latency: accepted at edge N -> out_valid=1 after edge N (visible in cycle N+1). No same-cycle bypass.
- Pop when out_valid && out_ready. out_instr/out_err show the head combinationally from storage; they hold stable while out_valid && !out_ready.
- in_ready = (count != DEPTH). When full, a simultaneous pop does NOT allow a same-cycle push.
- Simultaneous push+pop when not full and not empty: count unchanged, pointers both advance.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Encodings (bit ranges MSB..LSB):
  R: funct7|rs2|rs1|funct3|rd|opcode
  I: imm[11:0]|rs1|funct3|rd|opcode
  S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  U: imm[31:12]|rd|opcode
- Range errors set err but still encode the truncated bits:
  - I/S: imm must be the sign-extension of imm[11:0].
  - B: imm must be the sign-extension of imm[12:0], with imm[0]=0.
  - J: imm must be the sign-extension of imm[20:0], with imm[0]=0.
  - U: imm[11:0] must be 0.
  - R: imm ignored, never an error.
- Illegal fmt (6, 7): word = 0x00000013 (nop), err=1.
- Reset mid-operation discards all queued entries; no partial entry survives.

Optional Feature:
Macro ENCODER_ROUNDTRIP_CHECK_EN.
- Defined: a decoder instance is fed out_instr. On every pop of an entry with err=0, its rs1/rs2/rd/imm (per format, imm truncated to that format's range) are compared against fields stored alongside the entry. Any mismatch sets chk_mismatch=1, held until reset. This adds per-entry field storage.
- Undefined: no decoder instance and no extra storage; chk_mismatch tied to 0.

Test Plan:
- R/I: fmt=0, opcode=`OPCODE_ALU, funct7=0, funct3=0, rs1=2, rs2=3, rd=1 -> out_instr=0x003100b3, out_err=0, out_valid one cycle after accept. Then fmt=1, `OPCODE_LOAD, funct3=2, rs1=3, rd=1, imm=1 -> 0x0011a083.
- S/B: fmt=2, `OPCODE_STORE, funct3=2, rs1=3, rs2=1, imm=1 -> 0x0011a0a3. Then fmt=3, `OPCODE_BRANCH, funct3=0, rs1=rs2=1, imm=-0x18 -> 0xfe1084e3.
- J: fmt=4, `OPCODE_JUMP, rd=1, imm=-0x10 -> 0xff1ff0ef. Then rd=0, imm=-0x14 -> 0xfedff06f.
- Errors:
  - fmt=1, imm=2048 -> out_err=1, out_instr=0x80000000|fields.
  - fmt=3, imm=3 -> out_err=1.
  - fmt=7 -> 0x00000013, out_err=1.
- Backpressure: out_ready=0, push 4 entries (DEPTH=4) -> count=4, in_ready=0, fifth request held off. Then out_ready=1 for 4 cycles with in_valid=0 -> entries pop in order, count returns to 0, out_valid=0.
- Reset mid-stream: 3 entries queued, assert reset between edges -> out_valid=0, count=0 immediately. After release, a new push is accepted and appears as the first entry out.
